// File: rtl/exc_pkg.sv
// Shared constants and types for exception / ERTN commit sequencing.
// Holds LoongArch ecode values, the FSM state encoding, the event kind and
// the captured-exception payload, plus the BADV selection helpers.
package exc_pkg;

   // Exception codes
   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COMMIT   = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_REDIRECT = 2'd3;

   typedef enum logic {
      EV_EX   = 1'b0,
      EV_ERTN = 1'b1
   } ev_kind_e;

   // Exception payload captured from WB
   typedef struct packed {
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
      logic [31:0] era;
      logic [31:0] badv;
   } exc_rec_t;

   // Address-class exceptions are the only ones that update BADV
   function automatic logic badv_needed(input logic [5:0] ecode);
      return (ecode == ECODE_ADE) || (ecode == ECODE_ALE);
   endfunction

   // Fetch-side ADE reports the PC itself; everything else the data address
   function automatic logic [31:0] badv_sel(input logic [5:0]  ecode,
                                            input logic [8:0]  esubcode,
                                            input logic [31:0] pc,
                                            input logic [31:0] vaddr);
      return ((ecode == ECODE_ADE) && (esubcode == ESUBCODE_ADEF)) ? pc : vaddr;
   endfunction

endpackage

// File: rtl/exc_flush_ctrl_sat_counter.sv
// Saturating up-counter used for exception/ERTN event statistics.
// Ports: clk, resetn (async active-low), inc (count enable), count (W bits,
// sticks at all-ones).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception / ERTN commit and pipeline flush controller.
// Captures a WB exception or ertn, pulses the CSR commit strobes one cycle
// later, keeps the pipeline flushed for FLUSH_CYCLES drain cycles and then
// offers the redirect PC to IF over a valid/ready handshake.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   wb_ex/wb_ecode/wb_esubcode/...   WB exception event and its attributes
//   ertn_flush                       WB ertn event
//   csr_eentry, csr_era              redirect targets from the CSR file
//   csr_*_we / csr_*_wdata           one-cycle CSR commit strobes and data
//   pipe_flush                       combinational kill of IF..WB
//   redirect_valid/pc/ready          redirect handshake towards IF
//   busy                             controller not idle
//   ex_count, ertn_count             event counters (EXC_STATS_EN only)
// Optional feature macro: EXC_STATS_EN.
module exc_flush_ctrl
   import exc_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned STAT_W       = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wb_ex,
   input  logic [5:0]        wb_ecode,
   input  logic [8:0]        wb_esubcode,
   input  logic [31:0]       wb_pc,
   input  logic [31:0]       wb_vaddr,
   input  logic              ertn_flush,
   input  logic [31:0]       csr_eentry,
   input  logic [31:0]       csr_era,
   output logic              csr_ex_we,
   output logic              csr_ertn_we,
   output logic [5:0]        csr_ecode,
   output logic [8:0]        csr_esubcode,
   output logic [31:0]       csr_era_wdata,
   output logic              csr_badv_we,
   output logic [31:0]       csr_badv_wdata,
   output logic              pipe_flush,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   input  logic              redirect_ready,
   output logic              busy
`ifdef EXC_STATS_EN
   ,
   output logic [STAT_W-1:0] ex_count,
   output logic [STAT_W-1:0] ertn_count
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] DRAIN_INIT =
      CNT_W'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;
   ev_kind_e         kind;
   logic             ex_we_d, ertn_we_d, badv_we_d, rv_d, busy_d;
   exc_rec_t         rec_q;

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      kind      = EV_EX;
      case (state_q)
         ST_IDLE: begin
            // wb_ex has priority; a simultaneous ertn is dropped
            if (wb_ex) begin
               capture = 1'b1;
               kind    = EV_EX;
               state_d = ST_COMMIT;
            end else if (ertn_flush) begin
               capture = 1'b1;
               kind    = EV_ERTN;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            if (FLUSH_CYCLES == 0) begin
               state_d = ST_REDIRECT;
            end else begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_INIT;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_REDIRECT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Strobes are registered so they appear in the COMMIT cycle
      ex_we_d   = capture && (kind == EV_EX);
      ertn_we_d = capture && (kind == EV_ERTN);
      badv_we_d = ex_we_d && badv_needed(wb_ecode);
      rv_d      = (state_d == ST_REDIRECT);
      busy_d    = (state_d != ST_IDLE);
   end

   // State and control-output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         csr_ex_we      <= 1'b0;
         csr_ertn_we    <= 1'b0;
         csr_badv_we    <= 1'b0;
         redirect_valid <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         csr_ex_we      <= ex_we_d;
         csr_ertn_we    <= ertn_we_d;
         csr_badv_we    <= badv_we_d;
         redirect_valid <= rv_d;
         busy           <= busy_d;
      end
   end

   // Event payload capture; held until the next accepted event
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rec_q       <= '0;
         redirect_pc <= '0;
      end else if (capture) begin
         if (kind == EV_EX) begin
            rec_q       <= '{ecode:    wb_ecode,
                             esubcode: wb_esubcode,
                             era:      wb_pc,
                             badv:     badv_sel(wb_ecode, wb_esubcode, wb_pc, wb_vaddr)};
            redirect_pc <= csr_eentry;
         end else begin
            redirect_pc <= csr_era;
         end
      end
   end

   assign csr_ecode      = rec_q.ecode;
   assign csr_esubcode   = rec_q.esubcode;
   assign csr_era_wdata  = rec_q.era;
   assign csr_badv_wdata = rec_q.badv;

   // Same-cycle kill on the WB event, held until the redirect is taken;
   // forced low while reset is asserted
   assign pipe_flush = resetn && ((state_q != ST_IDLE) || wb_ex || ertn_flush);

`ifdef EXC_STATS_EN
   sat_counter #(.W(STAT_W)) u_ex_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (csr_ex_we),
      .count  (ex_count)
   );

   sat_counter #(.W(STAT_W)) u_ertn_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (csr_ertn_we),
      .count  (ertn_count)
   );
`else
   logic [STAT_W-1:0] unused_stat_w;
   assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Scoreboard bench for exc_flush_ctrl: randomized and directed WB events,
// a transaction-level reference model predicting per-cycle control outputs,
// commit payloads and redirect targets, and a monitor comparing them.
module tb_exc_flush_ctrl;

   localparam int FLUSH = 2;
`ifdef EXC_STATS_EN
   localparam int STAT_W = 2;
`else
   localparam int STAT_W = 16;
`endif

   logic        clk, resetn;
   logic        wb_ex, ertn_flush, redirect_ready;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr, csr_eentry, csr_era;
   logic        csr_ex_we, csr_ertn_we, csr_badv_we, pipe_flush, redirect_valid, busy;
   logic [5:0]  csr_ecode;
   logic [8:0]  csr_esubcode;
   logic [31:0] csr_era_wdata, csr_badv_wdata, redirect_pc;
`ifdef EXC_STATS_EN
   logic [STAT_W-1:0] ex_count, ertn_count;
`endif

   exc_flush_ctrl #(.FLUSH_CYCLES(FLUSH), .STAT_W(STAT_W)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .wb_ex          (wb_ex),
      .wb_ecode       (wb_ecode),
      .wb_esubcode    (wb_esubcode),
      .wb_pc          (wb_pc),
      .wb_vaddr       (wb_vaddr),
      .ertn_flush     (ertn_flush),
      .csr_eentry     (csr_eentry),
      .csr_era        (csr_era),
      .csr_ex_we      (csr_ex_we),
      .csr_ertn_we    (csr_ertn_we),
      .csr_ecode      (csr_ecode),
      .csr_esubcode   (csr_esubcode),
      .csr_era_wdata  (csr_era_wdata),
      .csr_badv_we    (csr_badv_we),
      .csr_badv_wdata (csr_badv_wdata),
      .pipe_flush     (pipe_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .busy           (busy)
`ifdef EXC_STATS_EN
      ,
      .ex_count       (ex_count),
      .ertn_count     (ertn_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit pf, bsy, rv, ex_we, ertn_we, badv_we;
      int exc, ertnc;
   } cyc_exp_t;

   typedef struct {
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] era;
      logic [31:0] badv;
      bit          chk_badv;
   } com_exp_t;

   cyc_exp_t    cycq[$];
   com_exp_t    comq[$];
   logic [31:0] rdq[$];

   int  n_checks = 0;
   int  n_errors = 0;
   bit  mon_en   = 1'b0;

   // Reference model state (transaction level)
   int  cyc_n = 0;
   bit  m_busy = 1'b0;
   int  m_commit = -100;
   bit  m_kind_ex = 1'b0;
   bit  m_badv = 1'b0;
   int  m_rv_start = 0;
   int  m_exc = 0, m_ertnc = 0;
   int  sat_max = (1 << STAT_W) - 1;

   logic [5:0] ecode_list [7] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h3F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s (cycle %0d)", name, cyc_n);
   endtask

   // One stimulus cycle: drive inputs after the edge and advance the model
   task automatic cycle(input bit ex, input bit ertn, input bit rdy,
                        input logic [5:0] ec, input logic [8:0] es,
                        input logic [31:0] pc, input logic [31:0] va,
                        input logic [31:0] ee, input logic [31:0] era);
      cyc_exp_t e;
      @(posedge clk);
      #1;
      wb_ex = ex; ertn_flush = ertn; redirect_ready = rdy;
      wb_ecode = ec; wb_esubcode = es; wb_pc = pc; wb_vaddr = va;
      csr_eentry = ee; csr_era = era;
      cyc_n++;
      if (cyc_n == m_commit + 1) begin
         if (m_kind_ex) m_exc = (m_exc < sat_max) ? m_exc + 1 : m_exc;
         else           m_ertnc = (m_ertnc < sat_max) ? m_ertnc + 1 : m_ertnc;
      end
      e = '{default: 0};
      if (!m_busy) begin
         if (ex || ertn) begin
            e.pf       = 1'b1;
            m_busy     = 1'b1;
            m_commit   = cyc_n + 1;
            m_kind_ex  = ex;
            m_badv     = ex && (ec == 6'h08 || ec == 6'h09);
            m_rv_start = cyc_n + 2 + FLUSH;
            if (ex) begin
               comq.push_back('{ecode: ec, esub: es, era: pc,
                                badv: (ec == 6'h08 && es == 9'd0) ? pc : va,
                                chk_badv: m_badv});
               rdq.push_back(ee);
            end else begin
               rdq.push_back(era);
            end
         end
      end else begin
         e.pf      = 1'b1;
         e.bsy     = 1'b1;
         e.ex_we   = (cyc_n == m_commit) && m_kind_ex;
         e.ertn_we = (cyc_n == m_commit) && !m_kind_ex;
         e.badv_we = (cyc_n == m_commit) && m_badv;
         e.rv      = (cyc_n >= m_rv_start);
         if (e.rv && rdy) m_busy = 1'b0;
      end
      e.exc   = m_exc;
      e.ertnc = m_ertnc;
      if (mon_en) cycq.push_back(e);
   endtask

   task automatic idle_cycle(input bit rdy);
      cycle(1'b0, 1'b0, rdy, ecode_list[$urandom_range(0, 6)], 9'($urandom_range(0, 511)),
            $urandom, $urandom, $urandom, $urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && m_busy; i++) idle_cycle(1'b1);
      if (m_busy) fail_now("drain_timeout");
      idle_cycle(1'b1);
   endtask

   // Monitor: compares DUT outputs mid-cycle against the scoreboard
   initial begin
      cyc_exp_t e;
      com_exp_t c;
      forever begin
         @(negedge clk);
         if (mon_en && cycq.size() > 0) begin
            e = cycq.pop_front();
            chk("pipe_flush", 32'(pipe_flush), 32'(e.pf));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            chk("csr_ex_we", 32'(csr_ex_we), 32'(e.ex_we));
            chk("csr_ertn_we", 32'(csr_ertn_we), 32'(e.ertn_we));
            chk("csr_badv_we", 32'(csr_badv_we), 32'(e.badv_we));
`ifdef EXC_STATS_EN
            chk("ex_count", 32'(ex_count), 32'(e.exc));
            chk("ertn_count", 32'(ertn_count), 32'(e.ertnc));
`endif
            if (csr_ex_we) begin
               if (comq.size() == 0) begin
                  fail_now("commit_unexpected");
               end else begin
                  c = comq.pop_front();
                  chk("csr_ecode", 32'(csr_ecode), 32'(c.ecode));
                  chk("csr_esubcode", 32'(csr_esubcode), 32'(c.esub));
                  chk("csr_era_wdata", csr_era_wdata, c.era);
                  if (c.chk_badv) chk("csr_badv_wdata", csr_badv_wdata, c.badv);
               end
            end
            if (redirect_valid) begin
               if (rdq.size() == 0) begin
                  fail_now("redirect_unexpected");
               end else begin
                  chk("redirect_pc", redirect_pc, rdq[0]);
                  if (redirect_ready) void'(rdq.pop_front());
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      resetn = 1'b0;
      wb_ex = 1'b0; ertn_flush = 1'b0; redirect_ready = 1'b0;
      wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
      csr_eentry = '0; csr_era = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_csr_ex_we", 32'(csr_ex_we), 0);
      chk("rst_csr_ertn_we", 32'(csr_ertn_we), 0);
      chk("rst_pipe_flush", 32'(pipe_flush), 0);
      chk("rst_redirect_valid", 32'(redirect_valid), 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_csr_era_wdata", csr_era_wdata, 0);
      resetn = 1'b1;
      mon_en = 1'b1;
      idle_cycle(1'b1);

      // SYS
      cycle(1, 0, 1, 6'h0B, 9'd0, 32'h1C000100, 32'h12345678, 32'h1C008000, 32'hDEAD0000);
      drain();
      // ALE
      cycle(1, 0, 1, 6'h09, 9'd0, 32'h1C000200, 32'h00000003, 32'h1C008000, 32'h0);
      drain();
      // ADEF
      cycle(1, 0, 1, 6'h08, 9'd0, 32'h1C000002, 32'hABCD0000, 32'h1C008000, 32'h0);
      drain();
      // ADEM (ADE with non-zero subcode reports vaddr)
      cycle(1, 0, 1, 6'h08, 9'd1, 32'h1C000300, 32'h0BAD0004, 32'h1C008000, 32'h0);
      drain();
      // ERTN
      cycle(0, 1, 1, 6'h0B, 9'd0, 32'h1C000500, 32'h0, 32'h1C008000, 32'h1C000104);
      drain();
      // Simultaneous wb_ex and ertn_flush
      cycle(1, 1, 1, 6'h0C, 9'd0, 32'h1C000600, 32'h0, 32'h1C008000, 32'h1C000104);
      drain();
      // Late events during COMMIT/DRAIN are ignored
      cycle(1, 0, 1, 6'h0D, 9'd0, 32'h1C000700, 32'h0, 32'h1C008000, 32'h0);
      cycle(1, 0, 1, 6'h09, 9'd0, 32'h1C000800, 32'h4, 32'h11111110, 32'h0);
      cycle(1, 1, 1, 6'h09, 9'd0, 32'h1C000900, 32'h5, 32'h22222220, 32'h0);
      drain();
      // Backpressure: ready low for 5 valid cycles
      cycle(1, 0, 0, 6'h3F, 9'd0, 32'h1C000A00, 32'h0, 32'h1C00F000, 32'h0);
      repeat (FLUSH + 1 + 5) idle_cycle(1'b0);
      drain();
      // Back-to-back events: accepted the cycle after the handshake
      for (int k = 0; k < 6; k++) begin
         cycle(1, 0, 1, 6'h0B, 9'd0, 32'h1C001000 + 32'(k), 32'h0, 32'h1C008000, 32'h0);
         repeat (FLUSH + 2) cycle(1, 0, 1, 6'h0B, 9'd0, $urandom, $urandom, $urandom, $urandom);
      end
      drain();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) < 7,
               ecode_list[$urandom_range(0, 6)],
               ($urandom_range(0, 1) == 0) ? 9'd0 : 9'($urandom_range(0, 511)),
               $urandom, $urandom, $urandom, $urandom);
      end
      drain();

      // Asynchronous reset while draining
      cycle(1, 0, 1, 6'h09, 9'd0, 32'h1C002000, 32'h7, 32'h1C008000, 32'h0);
      idle_cycle(1'b1);
      cycle(0, 0, 1, 6'h00, 9'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      resetn = 1'b0;
      #1;
      chk("arst_csr_ex_we", 32'(csr_ex_we), 0);
      chk("arst_csr_ertn_we", 32'(csr_ertn_we), 0);
      chk("arst_csr_badv_we", 32'(csr_badv_we), 0);
      chk("arst_csr_ecode", 32'(csr_ecode), 0);
      chk("arst_csr_esubcode", 32'(csr_esubcode), 0);
      chk("arst_csr_era_wdata", csr_era_wdata, 0);
      chk("arst_csr_badv_wdata", csr_badv_wdata, 0);
      chk("arst_pipe_flush", 32'(pipe_flush), 0);
      chk("arst_redirect_valid", 32'(redirect_valid), 0);
      chk("arst_redirect_pc", redirect_pc, 0);
      chk("arst_busy", 32'(busy), 0);
`ifdef EXC_STATS_EN
      chk("arst_ex_count", 32'(ex_count), 0);
      chk("arst_ertn_count", 32'(ertn_count), 0);
`endif
      cycq.delete();
      comq.delete();
      rdq.delete();
      m_busy = 1'b0;
      m_commit = -100;
      m_exc = 0;
      m_ertnc = 0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      mon_en = 1'b1;

      // Recovery after reset
      cycle(1, 0, 1, 6'h0B, 9'd0, 32'h1C000100, 32'h0, 32'h1C008000, 32'h0);
      drain();

      @(negedge clk);
      #1;
      chk("leftover_commits", 32'(comq.size()), 0);
      chk("leftover_redirects", 32'(rdq.size()), 0);
      chk("leftover_cycles", 32'(cycq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
